// File: rtl/block_mem_pkg.sv
// Shared definitions for the block-granular main memory controller.
// Holds the controller state encoding, the request-type encoding and the
// default parameter values (with the block width / index width that follow
// from them) used by block_memory_ctrl and mem_block_array.
package block_mem_pkg;

    localparam int DEF_BLOCK_BYTES    = 16;
    localparam int DEF_ADDR_W         = 28;
    localparam int DEF_DEPTH_BLOCKS   = 32768;
    localparam int DEF_ACCESS_LATENCY = 5;
    localparam int DEF_INIT_CLEAR     = 1;

    // Block width in bits and storage index width at the default geometry.
    localparam int DATA_W = 8 * DEF_BLOCK_BYTES;
    localparam int IDX_W  = $clog2(DEF_DEPTH_BLOCKS);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/mem_block_array.sv
// Single-port block storage: DEPTH_BLOCKS blocks of 8*BLOCK_BYTES bits.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (read register only)
//   we, wmask - write enable and per-byte write mask (byte i = bits 8i+7:8i)
//   re, rclr  - load read register from storage / force read register to 0
//   addr      - block index
//   wdata     - write block
//   rdata     - registered read block, held until the next re or rclr
// Storage itself has no reset; the controller's INIT sequence zeroes it.
module mem_block_array #(
    parameter int BLOCK_BYTES  = 16,
    parameter int DEPTH_BLOCKS = 32768,
    parameter int DATA_W       = 8 * BLOCK_BYTES,
    parameter int IDX_W        = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic                   re,
    input  logic                   rclr,
    input  logic [IDX_W-1:0]       addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic [BLOCK_BYTES-1:0] wmask,
    output logic [DATA_W-1:0]      rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH_BLOCKS];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Per-byte masked write into storage
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BLOCK_BYTES; b++) begin
                if (wmask[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Next read-register value: clear wins over load, otherwise hold
    always_comb begin
        rdata_d = rdata_q;
        if (rclr) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[addr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/block_memory_ctrl.sv
// Block-granular main memory with READ/WRITE/BUSYWAIT handshake.
// Ports:
//   CLK, RESET  - clock, asynchronous active-high reset
//   READ, WRITE - block request (exactly one high starts an access)
//   ADDRESS     - block index, sampled only when the request is accepted
//   WRITEDATA   - write block, byte i at bits 8i+7:8i
//   WRITEMASK   - per-byte write enable
//   READDATA    - registered read block, held until the next completed read
//   BUSYWAIT    - stall: high in INIT, on the accepting IDLE cycle and in WAIT
//   ERROR       - latched address out of range, high only in the DONE cycle
//   PROTERR     - one-cycle pulse after READ and WRITE were both high in IDLE
// An access keeps BUSYWAIT high for ACCESS_LATENCY+1 cycles, then DONE
// drops it for one cycle. After reset an optional INIT pass zeroes one block
// per cycle before requests are accepted.
module block_memory_ctrl
    import block_mem_pkg::*;
#(
    parameter int BLOCK_BYTES    = DEF_BLOCK_BYTES,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH_BLOCKS   = DEF_DEPTH_BLOCKS,
    parameter int ACCESS_LATENCY = DEF_ACCESS_LATENCY,
    parameter int INIT_CLEAR     = DEF_INIT_CLEAR
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic [ADDR_W-1:0]        ADDRESS,
    input  logic [8*BLOCK_BYTES-1:0] WRITEDATA,
    input  logic [BLOCK_BYTES-1:0]   WRITEMASK,
    output logic [8*BLOCK_BYTES-1:0] READDATA,
    output logic                     BUSYWAIT,
    output logic                     ERROR,
    output logic                     PROTERR
);

    localparam int BLK_DATA_W = 8 * BLOCK_BYTES;
    localparam int BLK_IDX_W  = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
    localparam int CNT_W      = $clog2(ACCESS_LATENCY + 1);

    localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(ACCESS_LATENCY - 1);
    localparam logic [BLK_IDX_W-1:0] IDX_LAST  = BLK_IDX_W'(DEPTH_BLOCKS - 1);
    localparam mem_state_e           RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;

    mem_state_e               state_q,    state_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;
    logic [BLK_IDX_W-1:0]     init_idx_q, init_idx_d;
    mem_op_e                  op_q,       op_d;
    logic [ADDR_W-1:0]        addr_q,     addr_d;
    logic [BLK_DATA_W-1:0]    wdata_q,    wdata_d;
    logic [BLOCK_BYTES-1:0]   wmask_q,    wmask_d;
    logic                     error_q,    error_d;
    logic                     proterr_q,  proterr_d;

    logic                     busy_s;
    logic                     in_range_s;
    logic                     arr_we_s;
    logic                     arr_re_s;
    logic                     arr_rclr_s;
    logic [BLK_IDX_W-1:0]     arr_addr_s;
    logic [BLK_DATA_W-1:0]    arr_wdata_s;
    logic [BLOCK_BYTES-1:0]   arr_wmask_s;

    // Range check on the latched address; widened so any ADDR_W compares safely
    always_comb begin
        in_range_s = (65'(addr_q) < 65'(DEPTH_BLOCKS));
    end

    // Next-state, datapath capture and storage control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        error_d     = 1'b0;
        proterr_d   = 1'b0;
        busy_s      = 1'b0;
        arr_we_s    = 1'b0;
        arr_re_s    = 1'b0;
        arr_rclr_s  = 1'b0;
        arr_addr_s  = BLK_IDX_W'(addr_q);
        arr_wdata_s = wdata_q;
        arr_wmask_s = wmask_q;

        case (state_q)
            ST_INIT: begin
                // Zero one block per cycle, requests are ignored meanwhile
                busy_s      = 1'b1;
                arr_we_s    = 1'b1;
                arr_addr_s  = init_idx_q;
                arr_wdata_s = '0;
                arr_wmask_s = '1;
                if (init_idx_q == IDX_LAST) begin
                    init_idx_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    init_idx_d = init_idx_q + BLK_IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (READ && WRITE) begin
                    // Conflicting request: flag it, do not start an access
                    proterr_d = 1'b1;
                end else if (READ || WRITE) begin
                    busy_s  = 1'b1;
                    op_d    = WRITE ? OP_WRITE : OP_READ;
                    addr_d  = ADDRESS;
                    wdata_d = WRITEDATA;
                    wmask_d = WRITEMASK;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_WAIT: begin
                busy_s = 1'b1;
                if (cnt_q == '0) begin
                    // Final wait edge: commit the latched access
                    state_d = ST_DONE;
                    error_d = ~in_range_s;
                    if (in_range_s) begin
                        if (op_q == OP_WRITE) begin
                            arr_we_s = 1'b1;
                        end else begin
                            arr_re_s = 1'b1;
                        end
                    end else if (op_q == OP_READ) begin
                        arr_rclr_s = 1'b1;
                    end else begin
                        arr_we_s = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; an asserted RESET discards any access in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            init_idx_q <= '0;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            error_q    <= 1'b0;
            proterr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            error_q    <= error_d;
            proterr_q  <= proterr_d;
        end
    end

    mem_block_array #(
        .BLOCK_BYTES  (BLOCK_BYTES),
        .DEPTH_BLOCKS (DEPTH_BLOCKS),
        .DATA_W       (BLK_DATA_W),
        .IDX_W        (BLK_IDX_W)
    ) u_array (
        .clk   (CLK),
        .rst   (RESET),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .rclr  (arr_rclr_s),
        .addr  (arr_addr_s),
        .wdata (arr_wdata_s),
        .wmask (arr_wmask_s),
        .rdata (READDATA)
    );

    // BUSYWAIT must react in the same cycle a request appears in IDLE
    assign BUSYWAIT = busy_s;
    assign ERROR    = error_q;
    assign PROTERR  = proterr_q;

endmodule

// File: tb/tb_block_memory_ctrl.sv
// Self-checking bench for block_memory_ctrl (64 blocks of 16 bytes).
// Expected outputs come from a transaction-level model: a plain array of
// blocks plus the handshake timing rules (request cycle + ACCESS_LATENCY
// busy cycles, then one DONE cycle). A second instance with latency 1
// checks the short-latency handshake.
module tb_block_memory_ctrl;

    localparam int BB  = 16;
    localparam int AW  = 28;
    localparam int DEP = 64;
    localparam int LAT = 5;
    localparam int DW  = 8 * BB;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          READ, WRITE, r1, w1;
    logic [AW-1:0] ADDRESS;
    logic [DW-1:0] WRITEDATA;
    logic [BB-1:0] WRITEMASK;
    logic [DW-1:0] rd, rd1;
    logic          bw, er, pe, bw1, er1, pe1;

    block_memory_ctrl #(.BLOCK_BYTES(BB), .ADDR_W(AW), .DEPTH_BLOCKS(DEP),
                        .ACCESS_LATENCY(LAT), .INIT_CLEAR(1)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .WRITEMASK(WRITEMASK), .READDATA(rd),
        .BUSYWAIT(bw), .ERROR(er), .PROTERR(pe));

    block_memory_ctrl #(.BLOCK_BYTES(BB), .ADDR_W(AW), .DEPTH_BLOCKS(DEP),
                        .ACCESS_LATENCY(1), .INIT_CLEAR(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .READ(r1), .WRITE(w1), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .WRITEMASK(WRITEMASK), .READDATA(rd1),
        .BUSYWAIT(bw1), .ERROR(er1), .PROTERR(pe1));

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mmem [DEP];
    logic          chk_en = 1'b0;
    logic          exp_busy, exp_err, exp_prot;
    logic [DW-1:0] exp_rdata;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model's expected outputs
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busywait", DW'(bw), DW'(exp_busy));
            chk("readdata", rd, exp_rdata);
            chk("error", DW'(er), DW'(exp_err));
            chk("proterr", DW'(pe), DW'(exp_prot));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_reset_expect();
        exp_busy  = 1'b1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        exp_prot  = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        int ic;
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; r1 = 1'b0; w1 = 1'b0;
        set_reset_expect();
        for (int i = 0; i < DEP; i++) mmem[i] = '0;
        repeat (hold) tick();
        RESET = 1'b0;
        ic = 0;
        for (int i = 0; i < DEP; i++) begin
            exp_busy = 1'b1;
            #1; if (bw) ic++;
            tick();
        end
        exp_busy = 1'b0;
        #1;
        chk("init_busy_cycles", DW'(ic), DW'(64));
        chk("init_end_busy", DW'(bw), '0);
        chk("init_end_busy_lat1", DW'(bw1), '0);
    endtask

    // One access; abort_wait>0 asserts RESET in that WAIT cycle and returns
    task automatic do_access(input bit is_wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [BB-1:0] mask,
                             input int abort_wait, output int bcnt);
        bit oor;
        int ai;
        oor  = (addr >= AW'(DEP));
        ai   = oor ? 0 : int'(addr);
        bcnt = 0;
        READ = !is_wr; WRITE = is_wr;
        ADDRESS = addr; WRITEDATA = data; WRITEMASK = mask;
        exp_busy = 1'b1;
        #1; if (bw) bcnt++;
        tick();
        exp_prot = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            if (i == abort_wait) begin
                RESET = 1'b1;
                set_reset_expect();
                return;
            end
            // Requester may drop the request or wiggle inputs; both are ignored
            if ($urandom_range(1, 0) == 1) begin READ = 1'b0; WRITE = 1'b0; end
            ADDRESS   = AW'($urandom);
            WRITEDATA = {$urandom, $urandom, $urandom, $urandom};
            WRITEMASK = BB'($urandom);
            exp_busy  = 1'b1;
            #1; if (bw) bcnt++;
            tick();
        end
        // DONE cycle: access result becomes visible
        READ = 1'b0; WRITE = 1'b0;
        exp_busy = 1'b0;
        exp_err  = oor;
        if (!is_wr) begin
            exp_rdata = oor ? '0 : mmem[ai];
        end else if (!oor) begin
            for (int b = 0; b < BB; b++)
                if (mask[b]) mmem[ai][8*b +: 8] = data[8*b +: 8];
        end
        #1; if (bw) bcnt++;
        tick();
        exp_err = 1'b0;
    endtask

    task automatic both_high();
        READ = 1'b1; WRITE = 1'b1; ADDRESS = AW'($urandom_range(DEP - 1, 0));
        WRITEDATA = {$urandom, $urandom, $urandom, $urandom}; WRITEMASK = '1;
        exp_busy = 1'b0;
        tick();
        exp_prot = 1'b1;
        READ = 1'b0; WRITE = 1'b0;
        tick();
        exp_prot = 1'b0;
    endtask

    task automatic dut1_access(input bit is_wr, output int bcnt);
        r1 = !is_wr; w1 = is_wr; bcnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bw1) bcnt++;
            else break;
            tick();
            r1 = 1'b0; w1 = 1'b0;
        end
        r1 = 1'b0; w1 = 1'b0;
        tick();
    endtask

    localparam logic [DW-1:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [DW-1:0] D1M  = 128'h00112233_44556677_8899AABB_CCDDEEA5;
    localparam logic [DW-1:0] DA5  = {16{8'hA5}};
    localparam logic [DW-1:0] D2   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    initial begin
        int bc;
        int kind, r;
        logic [AW-1:0] a;
        READ = 1'b0; WRITE = 1'b0; r1 = 1'b0; w1 = 1'b0;
        ADDRESS = '0; WRITEDATA = '0; WRITEMASK = '0;
        RESET = 1'b1;
        set_reset_expect();
        chk_en = 1'b1;
        do_reset(2);

        // Freshly cleared top block
        do_access(1'b0, AW'(63), '0, '0, 0, bc);
        chk("read63_zero", rd, '0);
        chk("read_busy_cycles", DW'(bc), DW'(6));

        // Full write then read back
        do_access(1'b1, AW'(5), D1, 16'hFFFF, 0, bc);
        chk("write_busy_cycles", DW'(bc), DW'(6));
        do_access(1'b0, AW'(5), '0, '0, 0, bc);
        chk("read5_full", rd, D1);

        // Single-byte masked write
        do_access(1'b1, AW'(5), DA5, 16'h0001, 0, bc);
        do_access(1'b0, AW'(5), '0, '0, 0, bc);
        chk("read5_masked", rd, D1M);

        // Out-of-range read, then confirm storage untouched
        do_access(1'b0, AW'(DEP), '0, '0, 0, bc);
        chk("oor_rdata", rd, '0);
        chk("oor_error_one_cycle", DW'(er), '0);
        chk("oor_busy_cycles", DW'(bc), DW'(6));
        for (int i = 0; i < DEP; i++) do_access(1'b0, AW'(i), '0, '0, 0, bc);

        // Conflicting request
        both_high();
        do_access(1'b0, AW'(5), '0, '0, 0, bc);
        chk("read5_after_prot", rd, D1M);

        // Randomised traffic
        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(9, 0));
            r    = int'($urandom_range(7, 0));
            if (r == 0)      a = AW'(DEP + int'($urandom_range(3, 0)));
            else if (r == 1) a = AW'($urandom) | 28'h800_0000;
            else             a = AW'($urandom_range(DEP - 1, 0));
            if (kind == 0) begin
                both_high();
            end else if (kind == 1) begin
                READ = 1'b0; WRITE = 1'b0; ADDRESS = AW'($urandom);
                exp_busy = 1'b0;
                tick();
            end else begin
                do_access(kind < 6, a, {$urandom, $urandom, $urandom, $urandom},
                          BB'($urandom), 0, bc);
            end
        end

        // Reset in the 3rd WAIT cycle of a write to block 7
        do_access(1'b1, AW'(7), D2, '1, 0, bc);
        do_access(1'b0, AW'(7), '0, '0, 0, bc);
        chk("read7_before_abort", rd, D2);
        do_access(1'b1, AW'(7), DA5, '1, 3, bc);
        #1;
        chk("abort_rdata_reset", rd, '0);
        chk("abort_busy_init", DW'(bw), DW'(1));
        chk("abort_error_reset", DW'(er), '0);
        do_reset(1);
        do_access(1'b0, AW'(7), '0, '0, 0, bc);
        chk("read7_after_init", rd, '0);

        // Latency-1 instance: two busy cycles per access
        ADDRESS = AW'(9); WRITEDATA = D2; WRITEMASK = '1;
        dut1_access(1'b1, bc);
        chk("lat1_write_busy", DW'(bc), DW'(2));
        dut1_access(1'b0, bc);
        chk("lat1_read_busy", DW'(bc), DW'(2));
        chk("lat1_readdata", rd1, D2);
        chk("lat1_error", DW'(er1), '0);
        chk("lat1_proterr", DW'(pe1), '0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
